// File: rtl/ahb_reg_slave.sv
// AHB-Lite register-file slave: NUM_REGS x DATA_WIDTH registers, optional wait states, byte-lane writes.
// Define AHB_REG_SLAVE_ERR_RESP_EN to give illegal transfers a two-cycle ERROR response (ERR1/ERR2).
module ahb_reg_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELx,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY_IN,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY_OUT,
    output logic [1:0]            HRESP,
    output logic                  XFER_ERROR_ACCESS
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int ALSB      = $clog2(NUM_BYTES);
    localparam int IDXW      = ADDR_WIDTH - ALSB;
    localparam int RIW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [2:0]    MAX_SIZE   = 3'(ALSB);
    localparam logic [IDXW:0] NUM_REGS_L = (IDXW + 1)'(NUM_REGS);
    localparam logic [3:0]    WAIT_INIT  = 4'(WAIT_STATES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
`ifdef AHB_REG_SLAVE_ERR_RESP_EN
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;
`endif

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [3:0]            r_wait_cnt;
    logic [3:0]            w_wait_cnt_next;
    logic [ALSB-1:0]       r_addr_lo;
    logic [RIW-1:0]        r_idx;
    logic [2:0]            r_size;
    logic                  r_write;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [IDXW-1:0]       w_idx;
    logic [ALSB-1:0]       w_offset;
    logic [ALSB-1:0]       w_size_mask;
    logic                  w_err;
    logic                  w_can_accept;
    logic                  w_accept;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [NUM_BYTES-1:0]  w_be;
    logic                  w_unused;

    assign w_unused = ^{HBURST, HTRANS[0]};

    // Address-phase decode of the transfer currently on the bus.
    assign w_idx       = HADDR[ADDR_WIDTH-1:ALSB];
    assign w_offset    = HADDR[ALSB-1:0];
    assign w_size_mask = ~({ALSB{1'b1}} << HSIZE);
    assign w_err       = ({1'b0, w_idx} >= NUM_REGS_L)
                       | (HSIZE > MAX_SIZE)
                       | (|(w_offset & w_size_mask));

`ifdef AHB_REG_SLAVE_ERR_RESP_EN
    assign w_can_accept = (r_state == S_IDLE) | (r_state == S_DATA) | (r_state == S_ERR2);
`else
    assign w_can_accept = (r_state == S_IDLE) | (r_state == S_DATA);
`endif
    assign w_accept = HSELx & HTRANS[1] & HREADY_IN & w_can_accept;

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            S_WAIT: begin
                if (r_wait_cnt == 4'd1) begin
                    w_state_next = S_DATA;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                end
            end
`ifdef AHB_REG_SLAVE_ERR_RESP_EN
            S_ERR1: w_state_next = S_ERR2;
`endif
            default: begin
                // IDLE, DATA and ERR2 all open a new address phase when one is accepted.
                if (w_accept) begin
`ifdef AHB_REG_SLAVE_ERR_RESP_EN
                    if (w_err) begin
                        w_state_next = S_ERR1;
                    end else
`endif
                    if (WAIT_STATES > 0) begin
                        w_state_next    = S_WAIT;
                        w_wait_cnt_next = WAIT_INIT;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_addr_lo  <= '0;
            r_idx      <= '0;
            r_size     <= 3'd0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_accept) begin
                r_addr_lo <= w_offset;
                r_idx     <= w_idx[RIW-1:0];
                r_size    <= HSIZE;
                r_write   <= HWRITE;
                r_err     <= w_err;
            end
        end
    end

    // A lane is written when it falls in the same 2**size-byte block as the start address.
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
        localparam logic [ALSB-1:0] LANE = ALSB'(gi);
        assign w_be[gi] = ((LANE >> r_size) == (r_addr_lo >> r_size));
    end

    assign w_wr_en = (r_state == S_DATA) & r_write & ~r_err;
    assign w_rd_en = (r_state == S_DATA) & ~r_write & ~r_err;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (w_be[b]) begin
                    r_regs[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HRDATA = w_rd_en ? r_regs[r_idx] : '0;

`ifdef AHB_REG_SLAVE_ERR_RESP_EN
    assign HREADY_OUT        = ~((r_state == S_WAIT) | (r_state == S_ERR1));
    assign HRESP             = ((r_state == S_ERR1) | (r_state == S_ERR2)) ? 2'b01 : 2'b00;
    assign XFER_ERROR_ACCESS = (r_state == S_ERR1);
`else
    assign HREADY_OUT        = (r_state != S_WAIT);
    assign HRESP             = 2'b00;
    assign XFER_ERROR_ACCESS = 1'b0;
`endif

endmodule

// File: doc/ahb_reg_slave.md
AHB_REG_SLAVE -- requirements
Module: ahb_reg_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, sets the HADDR width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, sets the HWDATA/HRDATA width; the legal values are 32 and 64.
REQ-003 Parameter NUM_REGS, default 16, sets the number of DATA_WIDTH registers; it SHALL be at least 1 and SHALL be no more than 2**(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 Parameter WAIT_STATES, default 0, sets the number of wait cycles inserted per OKAY transfer; the legal range is 0 to 15.
REQ-005 The block SHALL have one clock and an asynchronous active-high reset.
REQ-006 HCLK  in  1  bus clock; all state SHALL be updated on its rising edge.
REQ-007 HRESET  in  1  asynchronous active-high reset.
REQ-008 HSELx  in  1  slave select.
REQ-009 HADDR  in  ADDR_WIDTH  byte address.
REQ-010 HTRANS  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-011 HWRITE  in  1  1 = write, 0 = read.
REQ-012 HSIZE  in  3  transfer size as log2 of the byte count.
REQ-013 HBURST  in  3  burst type; the block SHALL accept it and SHALL otherwise ignore it.
REQ-014 HWDATA  in  DATA_WIDTH  write data.
REQ-015 HREADY_IN  in  1  bus-level ready.
REQ-016 HRDATA  out  DATA_WIDTH  read data.
REQ-017 HREADY_OUT  out  1  slave ready.
REQ-018 HRESP  out  2  response: OKAY=0, ERROR=1.
REQ-019 XFER_ERROR_ACCESS  out  1  one-cycle pulse for each error transfer.

Function
REQ-020 A transfer SHALL be accepted when HSELx=1, HTRANS[1]=1 and HREADY_IN=1 on a rising edge; on acceptance the block SHALL register HADDR, HWRITE and HSIZE.
REQ-021 IDLE/BUSY transfers, and cycles with HSELx=0, SHALL get a zero-wait OKAY response and SHALL change no register.
REQ-022 Register index = HADDR[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)].
REQ-023 A transfer SHALL be an error transfer if any of the following holds: index >= NUM_REGS; HSIZE > log2(DATA_WIDTH/8); HADDR is not aligned to 2**HSIZE.
REQ-024 The FSM SHALL have the states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-025 FSM transitions:
- IDLE -> WAIT on a legal accept with WAIT_STATES>0.
- IDLE -> DATA on a legal accept with WAIT_STATES=0.
- WAIT -> DATA after WAIT_STATES cycles.
- DATA -> IDLE, or DATA -> a new data phase on a back-to-back accept.
- Any accept of an error transfer -> ERR1 -> ERR2 -> IDLE (or a new data phase).
REQ-026 In WAIT, HREADY_OUT SHALL be 0 and HRESP SHALL be OKAY.
REQ-027 In DATA, HREADY_OUT SHALL be 1 and HRESP SHALL be OKAY; this is the completion cycle.
REQ-028 A write SHALL update only the byte lanes selected by HSIZE and the registered HADDR low bits, using HWDATA sampled at the end of the completion cycle.
REQ-029 A read SHALL drive HRDATA with the full register word during the completion cycle; at all other times HRDATA SHALL be 0.
REQ-030 The block SHALL accept a new address phase during the completion cycle, so zero-wait back-to-back transfers sustain one transfer per cycle.
REQ-031 For a write to register R followed immediately by a read of R, the read SHALL return the newly written value.
REQ-032 Error response (macro defined): ERR1 SHALL drive HRESP=ERROR with HREADY_OUT=0; ERR2 SHALL drive HRESP=ERROR with HREADY_OUT=1; an error transfer SHALL write no register and SHALL read 0.
REQ-033 XFER_ERROR_ACCESS SHALL pulse high for exactly the ERR1 cycle.
REQ-034 An accept occurring during ERR1 SHALL be ignored.

Reset
REQ-035 While HRESET=1, the block SHALL immediately drive HREADY_OUT=1, HRESP=OKAY, HRDATA=0 and XFER_ERROR_ACCESS=0, set the FSM to IDLE and clear every register to 0.
REQ-036 An HRESET assertion during WAIT, DATA or an error state SHALL abandon the transfer; a write that has not completed SHALL NOT take effect.
REQ-037 After HRESET deasserts, the block SHALL accept a transfer on the first rising edge.

Configuration
REQ-038 Macro AHB_REG_SLAVE_ERR_RESP_EN defined: error transfers SHALL follow REQ-032 and REQ-033.
REQ-039 Macro AHB_REG_SLAVE_ERR_RESP_EN undefined:
- Error transfers SHALL complete as an OKAY transfer with normal wait states.
- They SHALL write nothing and SHALL read 0.
- XFER_ERROR_ACCESS SHALL be tied to 0.
- The ERR1 and ERR2 states SHALL be absent.

Verification (DATA_WIDTH=32, NUM_REGS=16 unless stated)
REQ-040 Zero-wait write of 0xDEADBEEF to 0x008, then read of 0x008 -> read completes in 1 cycle, HRDATA=0xDEADBEEF, HRESP=OKAY.
REQ-041 WAIT_STATES=3, read of 0x004 -> HREADY_OUT low for exactly 3 cycles, then high with the register value.
REQ-042 Byte write of 0xAB at 0x00E to a register holding 0x11223344 -> register reads 0x11AB3344.
REQ-043 Macro defined, write to 0x040 (index 16) -> ERR1/ERR2 sequence, one pulse on XFER_ERROR_ACCESS, all registers unchanged.
REQ-044 Macro undefined, same stimulus as REQ-043 -> OKAY response, no pulse on XFER_ERROR_ACCESS, all registers unchanged.
REQ-045 HRESET asserted in the middle of a WAIT_STATES=2 write -> outputs at reset values immediately, target register reads 0 afterwards.
